// File: rtl/rf_wr_arb.sv
// rf_wr_arb: two-requester register-file write arbiter.
//   Requester 0 (ALU) and requester 1 (load unit) each feed a one-entry
//   holding buffer. A round-robin pointer picks which full buffer drives the
//   single registered write port. The write port goes to the decoder one
//   cycle after the grant.
// Ports:
//   clk, rst_n         clock, synchronous active-low reset
//   stall              blocks new grants; buffers and pointer hold
//   v0/a0/d0/r0        requester 0 valid/addr/data/ready
//   v1/a1/d1/r1        requester 1 valid/addr/data/ready
//   wr_en/addr/data    registered write strobe, address and data
//   conflict_cnt       saturating count of unstalled cycles with both full

// One holding buffer per requester.
module rf_wr_buf #(
  parameter int DW = 16,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          v,
  input  logic [AW-1:0] a,
  input  logic [DW-1:0] d,
  input  logic          gnt,
  output logic          r,
  output logic          bv,
  output logic [AW-1:0] ba,
  output logic [DW-1:0] bd
);
  // Ready when empty, or when the entry leaves this cycle (pass-through
  // refill). Held high during reset; the reset branch below wins.
  assign r = !rst_n || !bv || gnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bv <= 1'b0;
      ba <= '0;
      bd <= '0;
    end else if (v && r) begin
      bv <= 1'b1;
      ba <= a;
      bd <= d;
    end else if (gnt) begin
      bv <= 1'b0;
    end
  end
endmodule

module rf_wr_arb #(
  parameter int DW = 16,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          stall,
  input  logic          v0,
  input  logic [AW-1:0] a0,
  input  logic [DW-1:0] d0,
  output logic          r0,
  input  logic          v1,
  input  logic [AW-1:0] a1,
  input  logic [DW-1:0] d1,
  output logic          r1,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [DW-1:0] wr_data,
  output logic [7:0]    conflict_cnt
);
  localparam int NREQ = 2;

  typedef enum logic {P0 = 1'b0, P1 = 1'b1} arb_t;
  arb_t state, state_nxt;

  logic [NREQ-1:0]         vin, rdy, gnt, bv;
  logic [NREQ-1:0][AW-1:0] ain, ba;
  logic [NREQ-1:0][DW-1:0] din, bd;

  assign vin = {v1, v0};
  assign ain = {a1, a0};
  assign din = {d1, d0};
  assign r0  = rdy[0];
  assign r1  = rdy[1];

  for (genvar i = 0; i < NREQ; i++) begin : g_buf
    rf_wr_buf #(.DW(DW), .AW(AW)) u_buf (
      .clk(clk), .rst_n(rst_n),
      .v(vin[i]), .a(ain[i]), .d(din[i]),
      .gnt(gnt[i]), .r(rdy[i]),
      .bv(bv[i]), .ba(ba[i]), .bd(bd[i])
    );
  end

  // Grant: a lone full buffer wins; on contention the pointer decides.
  // The winner hands priority to the other side.
  always_comb begin
    gnt       = '0;
    state_nxt = state;
    if (!stall) begin
      case (bv)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = (state == P0) ? 2'b01 : 2'b10;
        default: gnt = '0;
      endcase
    end
    if (gnt[0]) state_nxt = P1;
    if (gnt[1]) state_nxt = P0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= P0;
    else        state <= state_nxt;
  end

  // Write port: strobe pulses once per grant; addr/data hold between writes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      wr_en <= |gnt;
      if (gnt[0]) begin
        wr_addr <= ba[0];
        wr_data <= bd[0];
      end else if (gnt[1]) begin
        wr_addr <= ba[1];
        wr_data <= bd[1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n)
      conflict_cnt <= '0;
    else if ((bv == 2'b11) && !stall && (conflict_cnt != 8'hFF))
      conflict_cnt <= conflict_cnt + 8'd1;
  end
endmodule

// File: tb/tb_rf_wr_arb.sv
module tb_rf_wr_arb;
  logic        clk = 1'b0;
  logic        rst_n, stall, v0, v1, r0, r1, wr_en;
  logic [3:0]  a0, a1, wr_addr;
  logic [15:0] d0, d1, wr_data;
  logic [7:0]  conflict_cnt;

  int total = 0;
  int bad   = 0;

  // scoreboard: per-requester data queues plus expected grant order
  logic [19:0] qa0[$];
  logic [19:0] qa1[$];
  bit          qg[$];

  always #5 clk = ~clk;

  rf_wr_arb #(.DW(16), .AW(4)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall),
    .v0(v0), .a0(a0), .d0(d0), .r0(r0),
    .v1(v1), .a1(a1), .d1(d1), .r1(r1),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .conflict_cnt(conflict_cnt)
  );

  // write monitor: every strobe must match the next scoreboard entry
  always @(negedge clk) begin
    logic [19:0] exp;
    bit g;
    if (wr_en === 1'b1) begin
      total++;
      if (qg.size() == 0) begin
        bad++;
        $display("FAIL wr_unexpected got addr=%0h data=%0h want no write", wr_addr, wr_data);
      end else begin
        g = qg.pop_front();
        exp = 'x;
        if (g == 1'b0 && qa0.size() > 0) exp = qa0.pop_front();
        if (g == 1'b1 && qa1.size() > 0) exp = qa1.pop_front();
        if ({wr_addr, wr_data} !== exp) begin
          bad++;
          $display("FAIL wr_data_req%0d got %0h/%0h want %0h/%0h", g, wr_addr, wr_data, exp[19:16], exp[15:0]);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    v0 = 0; v1 = 0; stall = 0;
  endtask

  task automatic test_reset();
    step(); rst_n = 0; stall = 0; v0 = 1; v1 = 1; a0 = 4'h9; d0 = 16'hDEAD; a1 = 4'h6; d1 = 16'hBEEF;
    @(negedge clk);
    total++; if ({r0, r1} !== 2'b11) begin bad++; $display("FAIL rst_ready got %b want 11", {r0, r1}); end
    step();
    @(negedge clk);
    total++; if (wr_en !== 1'b0) begin bad++; $display("FAIL rst_wr_en got %b want 0", wr_en); end
    total++; if (wr_addr !== 4'h0) begin bad++; $display("FAIL rst_wr_addr got %h want 0", wr_addr); end
    total++; if (wr_data !== 16'h0) begin bad++; $display("FAIL rst_wr_data got %h want 0", wr_data); end
    total++; if (conflict_cnt !== 8'h0) begin bad++; $display("FAIL rst_cnt got %0d want 0", conflict_cnt); end
    step(); idle(); rst_n = 1;
    step();
    @(negedge clk);
    total++; if (wr_en !== 1'b0) begin bad++; $display("FAIL rst_no_capture got %b want 0", wr_en); end
    step();
  endtask

  task automatic test_single();
    step(); v0 = 1; a0 = 4'd3; d0 = 16'h00AA;
    qa0.push_back({4'd3, 16'h00AA}); qg.push_back(1'b0);
    @(negedge clk);
    total++; if (r0 !== 1'b1) begin bad++; $display("FAIL single_r0 got %b want 1", r0); end
    step(); v0 = 0;
    @(negedge clk);
    total++; if (wr_en !== 1'b0) begin bad++; $display("FAIL single_early got %b want 0", wr_en); end
    step();
    @(negedge clk);
    total++; if ({wr_en, wr_addr, wr_data} !== {1'b1, 4'd3, 16'h00AA})
      begin bad++; $display("FAIL single_write got %b/%h/%h want 1/3/00aa", wr_en, wr_addr, wr_data); end
    step();
    @(negedge clk);
    total++; if ({wr_en, wr_addr, wr_data} !== {1'b0, 4'd3, 16'h00AA})
      begin bad++; $display("FAIL single_hold got %b/%h/%h want 0/3/00aa", wr_en, wr_addr, wr_data); end
  endtask

  // pointer sits at 1 after the single grant to requester 0
  task automatic test_ptr();
    step(); v0 = 1; v1 = 1; a0 = 4'd7; d0 = 16'h0707; a1 = 4'd8; d1 = 16'h0808;
    qa0.push_back({4'd7, 16'h0707}); qa1.push_back({4'd8, 16'h0808});
    qg.push_back(1'b1); qg.push_back(1'b0);
    repeat (4) begin step(); idle(); end
  endtask

  task automatic test_same_reg();
    step(); rst_n = 0; idle();
    step(); rst_n = 1;
    step(); v0 = 1; v1 = 1; a0 = 4'd5; d0 = 16'h1111; a1 = 4'd5; d1 = 16'h2222;
    qa0.push_back({4'd5, 16'h1111}); qa1.push_back({4'd5, 16'h2222});
    qg.push_back(1'b0); qg.push_back(1'b1);
    step(); idle();
    @(negedge clk);
    total++; if ({r0, r1} !== 2'b10) begin bad++; $display("FAIL same_ready got %b want 10", {r0, r1}); end
    step();
    @(negedge clk);
    total++; if ({wr_en, wr_data} !== {1'b1, 16'h1111}) begin bad++; $display("FAIL same_first got %b/%h want 1/1111", wr_en, wr_data); end
    step();
    @(negedge clk);
    total++; if ({wr_en, wr_data} !== {1'b1, 16'h2222}) begin bad++; $display("FAIL same_second got %b/%h want 1/2222", wr_en, wr_data); end
    step();
    @(negedge clk);
    total++; if (wr_en !== 1'b0) begin bad++; $display("FAIL same_done got %b want 0", wr_en); end
    total++; if (conflict_cnt !== 8'd1) begin bad++; $display("FAIL same_cnt got %0d want 1", conflict_cnt); end
  endtask

  // both requesters valid for n cycles; first = requester the pointer favours
  task automatic test_back_to_back(input int n, input bit first);
    bit g, er0, er1;
    for (int k = 0; k < n + 4; k++) begin
      step();
      g = ((k % 2) == 1) ? first : !first;
      if (k < n) begin
        v0 = 1; v1 = 1;
        a0 = 4'(k % 8); d0 = 16'h1000 + 16'(k);
        a1 = 4'(8 + k % 8); d1 = 16'h2000 + 16'(k);
        er0 = (k == 0) || (g == 1'b0);
        er1 = (k == 0) || (g == 1'b1);
        if (er0) qa0.push_back({a0, d0});
        if (er1) qa1.push_back({a1, d1});
      end else begin
        idle();
      end
      if (k >= 1 && k <= n + 1) qg.push_back(g);
      @(negedge clk);
      if (k < n) begin
        total++; if ({r0, r1} !== {er0, er1}) begin bad++; $display("FAIL b2b_ready k=%0d got %b want %b", k, {r0, r1}, {er0, er1}); end
      end
      if (k >= 2 && k <= n + 2) begin
        total++; if (wr_en !== 1'b1) begin bad++; $display("FAIL b2b_wr_en k=%0d got %b want 1", k, wr_en); end
      end
      if (k == n + 3) begin
        total++; if (wr_en !== 1'b0) begin bad++; $display("FAIL b2b_drain got %b want 0", wr_en); end
      end
    end
  endtask

  task automatic test_stall();
    step(); v0 = 1; v1 = 1; a0 = 4'hA; d0 = 16'h0A0A; a1 = 4'hB; d1 = 16'h0B0B;
    qa0.push_back({4'hA, 16'h0A0A}); qa1.push_back({4'hB, 16'h0B0B});
    qg.push_back(1'b1); qg.push_back(1'b0);
    for (int k = 0; k < 3; k++) begin
      step(); v0 = 0; v1 = 0; stall = 1;
      @(negedge clk);
      total++; if ({r0, r1, wr_en} !== 3'b000) begin bad++; $display("FAIL stall_hold k=%0d got r=%b wr_en=%b want r=00 wr_en=0", k, {r0, r1}, wr_en); end
      total++; if (conflict_cnt !== 8'd11) begin bad++; $display("FAIL stall_cnt k=%0d got %0d want 11", k, conflict_cnt); end
    end
    step(); stall = 0;
    @(negedge clk);
    total++; if ({r0, r1} !== 2'b01) begin bad++; $display("FAIL stall_resume got %b want 01", {r0, r1}); end
    step();
    @(negedge clk);
    total++; if ({wr_en, wr_data} !== {1'b1, 16'h0B0B}) begin bad++; $display("FAIL stall_w1 got %b/%h want 1/0b0b", wr_en, wr_data); end
    step();
    @(negedge clk);
    total++; if ({wr_en, wr_data} !== {1'b1, 16'h0A0A}) begin bad++; $display("FAIL stall_w2 got %b/%h want 1/0a0a", wr_en, wr_data); end
    step();
    @(negedge clk);
    total++; if (conflict_cnt !== 8'd12) begin bad++; $display("FAIL stall_cnt_after got %0d want 12", conflict_cnt); end
  endtask

  task automatic test_saturate();
    test_back_to_back(300, 1'b1);
    @(negedge clk);
    total++; if (conflict_cnt !== 8'd255) begin bad++; $display("FAIL sat_cnt got %0d want 255", conflict_cnt); end
  endtask

  task automatic test_reset_mid();
    step(); v0 = 1; v1 = 1; a0 = 4'h1; d0 = 16'hAAAA; a1 = 4'h2; d1 = 16'hBBBB;
    step(); v0 = 0; v1 = 0; stall = 1; rst_n = 0;
    @(negedge clk);
    total++; if ({r0, r1} !== 2'b11) begin bad++; $display("FAIL mid_rst_ready got %b want 11", {r0, r1}); end
    step(); stall = 0; rst_n = 1;
    @(negedge clk);
    total++; if ({wr_en, r0, r1} !== 3'b011) begin bad++; $display("FAIL mid_release got wr_en=%b r=%b want 0/11", wr_en, {r0, r1}); end
    total++; if (conflict_cnt !== 8'd0) begin bad++; $display("FAIL mid_cnt got %0d want 0", conflict_cnt); end
    step();
    @(negedge clk);
    total++; if (wr_en !== 1'b0) begin bad++; $display("FAIL mid_no_strobe got %b want 0", wr_en); end
  endtask

  initial begin
    rst_n = 0; stall = 0; v0 = 0; v1 = 0; a0 = 0; a1 = 0; d0 = 0; d1 = 0;
    test_reset();
    test_single();
    test_ptr();
    test_same_reg();
    test_back_to_back(10, 1'b0);
    test_stall();
    test_saturate();
    test_reset_mid();
    step();
    total++; if (qg.size() != 0) begin bad++; $display("FAIL sb_leftover got %0d want 0", qg.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/rf_wr_arb.md
RF_WR_ARB -- requirements
Module: rf_wr_arb

Interface
REQ-001 Parameter DW, default 16, register data width.
REQ-002 Parameter AW, default 4, register address width (16 registers).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 stall  input  1  when 1, no new write issued; buffers and grant pointer hold.
REQ-006 v0  input  1  requester 0 (ALU) write request valid.
REQ-007 a0  input  AW  requester 0 destination register.
REQ-008 d0  input  DW  requester 0 write data.
REQ-009 r0  output  1  requester 0 ready; transfer when v0 and r0 both 1.
REQ-010 v1, a1, d1, r1  same widths and meanings as REQ-006..009, for requester 1 (load unit).
REQ-011 wr_en  output  1  registered write strobe; drives the write decoder enable.
REQ-012 wr_addr  output  AW  registered write address; drives the decoder select.
REQ-013 wr_data  output  DW  registered write data.
REQ-014 conflict_cnt  output  8  saturating count of cycles with both buffers full.

Function
REQ-015 Each requester SHALL have one holding buffer: valid bit, addr, data.
REQ-016 rN SHALL equal NOT bufN_valid, or 1 if bufN is being granted this cycle (pass-through refill).
REQ-017 On transfer, bufN SHALL capture aN/dN at the clock edge; bufN_valid set.
REQ-018 Arbiter state: ptr (1 bit) = requester with priority; states P0 (ptr=0), P1 (ptr=1).
REQ-019 Grant is evaluated each cycle with stall=0: only one buffer full -> grant it; both full -> grant ptr; neither -> no grant.
REQ-020 On grant to N: ptr SHALL move to the other requester; bufN_valid cleared unless refilled the same edge.
REQ-021 With no grant, ptr SHALL hold.
REQ-022 Granted entry SHALL appear on wr_en=1, wr_addr, wr_data on the cycle after the grant edge (latency 1 from buffer-full to write strobe).
REQ-023 wr_en SHALL be 1 for exactly one cycle per grant; 0 otherwise; wr_addr/wr_data hold last value when wr_en=0.
REQ-024 stall=1 SHALL force no grant; wr_en=0 next cycle; buffers, ptr unchanged; rN still follows REQ-016 (empty buffers may still fill).
REQ-025 Both buffers targeting the same register: writes SHALL issue in grant order on consecutive cycles; last-granted value wins.
REQ-026 Maximum throughput: one write per cycle; full buffer waits at most one grant of the other requester.
REQ-027 conflict_cnt SHALL increment when both buffers valid and stall=0, saturate at 255, never wrap.
REQ-028 Transfers into a full buffer SHALL NOT occur (r=0); data inputs ignored when v=0.

Reset
REQ-029 rst_n=0 at a rising edge SHALL clear buf0_valid, buf1_valid, wr_en, conflict_cnt to 0, wr_addr and wr_data to 0, ptr to 0 (P0).
REQ-030 During reset r0=r1=1 combinationally, but no transfer is captured.
REQ-031 Reset mid-operation SHALL discard buffered requests; no write strobe on the cycle after reset release.

Verification
REQ-032 Reset, then v0=1 a0=3 d0=0x00AA for one cycle -> wr_en=1, wr_addr=3, wr_data=0x00AA two edges later; ptr=1.
REQ-033 Both buffers loaded same cycle (a0=5 d0=0x1111, a1=5 d1=0x2222), ptr=0 -> writes to 5: 0x1111 then 0x2222 on consecutive cycles; conflict_cnt=1.
REQ-034 Both requesters valid continuously for 10 cycles -> wr_en=1 every cycle, grants alternate 0,1,0,1..., r0/r1 each high every other cycle.
REQ-035 Both buffers full, stall=1 for 3 cycles -> wr_en=0, r0=r1=0, ptr unchanged; after release writes resume in ptr order.
REQ-036 Both buffers held full with stall=0 for 300 cycles -> conflict_cnt=255, no wrap.
REQ-037 rst_n=0 asserted with both buffers full -> next cycle after release wr_en=0, r0=r1=1, conflict_cnt=0.
